// File: rtl/lpm_table_ctrl.sv
// LPM route table owner: arbitrates host table access against datapath lookups
// and runs longest-prefix match as a one-entry-per-cycle scan.
module lpm_table_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_DEPTH          = 32,
  parameter int TBL_ADDR_WIDTH     = 5
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESETN,
  input  logic                          lookup_req,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] lookup_ip,
  output logic                          lookup_busy,
  output logic                          lookup_done,
  output logic                          lpm_hit,
  output logic [C_S_AXI_DATA_WIDTH-1:0] nh_reg_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0] oq_reg_in,
  input  logic                          tbl_rd_req,
  input  logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  output logic                          tbl_rd_ack,
  input  logic                          tbl_wr_req,
  input  logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  output logic                          tbl_wr_ack,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] stats_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0] lookup_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] hit_count
);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef struct packed {
    logic [DW-1:0] ip;
    logic [DW-1:0] mask;
    logic [DW-1:0] nh;
    logic [DW-1:0] oq;
  } entry_t;

  typedef enum logic [2:0] {IDLE, SCAN, HOST_WR, HOST_RD, DONE} state_t;
  localparam logic GRANT_LK   = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

  state_t                    state_q;
  entry_t                    tbl_q [TBL_DEPTH];
  logic [TBL_ADDR_WIDTH-1:0] idx_q, wr_addr_q, rd_addr_q;
  entry_t                    wr_data_q;
  logic                      wr_pend_q, rd_pend_q, last_grant_q;
  logic [DW-1:0]             ip_q;
  logic                      best_vld_q;
  logic [DW-1:0]             best_mask_q, best_nh_q, best_oq_q;
  logic                      busy_q, done_q, hit_q, rd_ack_q, wr_ack_q;
  logic [DW-1:0]             nh_q, oq_q, lk_cnt_q, hit_cnt_q;
  entry_t                    rd_data_q;

  entry_t cur;
  logic   cur_match, take_d, host_req, grant_host_d;

  always_comb begin
    cur          = tbl_q[idx_q];
    cur_match    = (cur.oq != '1) && ((ip_q & cur.mask) == (cur.ip & cur.mask));
    // strict > keeps the lowest index among equal-length prefixes
    take_d       = cur_match && (!best_vld_q || (cur.mask > best_mask_q));
    host_req     = wr_pend_q | rd_pend_q;
    grant_host_d = host_req && (!lookup_req || (last_grant_q == GRANT_LK));
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '1;
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      last_grant_q <= GRANT_LK;
      ip_q         <= '0;
      best_vld_q   <= 1'b0;
      best_mask_q  <= '0;
      best_nh_q    <= '0;
      best_oq_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      nh_q         <= '0;
      oq_q         <= '0;
      lk_cnt_q     <= '0;
      hit_cnt_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      // a pulse that lands while its slot is occupied is dropped
      if (tbl_wr_req && !wr_pend_q) begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= tbl_wr_addr;
        wr_data_q <= tbl_wr_data;
      end
      if (tbl_rd_req && !rd_pend_q) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= tbl_rd_addr;
      end
      case (state_q)
        IDLE: begin
          if (grant_host_d) begin
            last_grant_q <= GRANT_HOST;
            state_q      <= wr_pend_q ? HOST_WR : HOST_RD;
          end else if (lookup_req) begin
            last_grant_q <= GRANT_LK;
            ip_q         <= lookup_ip;
            idx_q        <= '0;
            best_vld_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= SCAN;
          end
        end
        HOST_WR: begin
          tbl_q[wr_addr_q] <= wr_data_q;
          wr_ack_q         <= 1'b1;
          wr_pend_q        <= 1'b0;
          state_q          <= IDLE;
        end
        HOST_RD: begin
          rd_data_q <= tbl_q[rd_addr_q];
          rd_ack_q  <= 1'b1;
          rd_pend_q <= 1'b0;
          state_q   <= IDLE;
        end
        SCAN: begin
          if (take_d) begin
            best_vld_q  <= 1'b1;
            best_mask_q <= cur.mask;
            best_nh_q   <= cur.nh;
            best_oq_q   <= cur.oq;
          end
          idx_q <= idx_q + 1'b1;
          if (idx_q == TBL_ADDR_WIDTH'(TBL_DEPTH - 1)) state_q <= DONE;
        end
        DONE: begin
          done_q   <= 1'b1;
          hit_q    <= best_vld_q;
          nh_q     <= best_vld_q ? best_nh_q : '0;
          oq_q     <= best_vld_q ? best_oq_q : '0;
          lk_cnt_q <= lk_cnt_q + 1'b1;
          if (best_vld_q) hit_cnt_q <= hit_cnt_q + 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // clear overrides any increment made in DONE above
      if (stats_clear == DW'(1)) begin
        lk_cnt_q  <= '0;
        hit_cnt_q <= '0;
      end
    end
  end

  assign lookup_busy  = busy_q;
  assign lookup_done  = done_q;
  assign lpm_hit      = hit_q;
  assign nh_reg_in    = nh_q;
  assign oq_reg_in    = oq_q;
  assign tbl_rd_data  = rd_data_q;
  assign tbl_rd_ack   = rd_ack_q;
  assign tbl_wr_ack   = wr_ack_q;
  assign lookup_count = lk_cnt_q;
  assign hit_count    = hit_cnt_q;

endmodule

// File: tb/tb_lpm_table_ctrl.sv
// Randomized bench for lpm_table_ctrl against an array-based LPM reference model.
module tb_lpm_table_ctrl;
  logic         clk = 1'b0;
  logic         rstn;
  logic         lookup_req;
  logic [31:0]  lookup_ip;
  logic         lookup_busy, lookup_done, lpm_hit;
  logic [31:0]  nh_reg_in, oq_reg_in;
  logic         tbl_rd_req, tbl_wr_req, tbl_rd_ack, tbl_wr_ack;
  logic [4:0]   tbl_rd_addr, tbl_wr_addr;
  logic [127:0] tbl_rd_data, tbl_wr_data;
  logic [31:0]  stats_clear, lookup_count, hit_count;

  always #5 clk = ~clk;

  lpm_table_ctrl dut (
    .AXI_ACLK(clk), .AXI_RESETN(rstn),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_busy(lookup_busy),
    .lookup_done(lookup_done), .lpm_hit(lpm_hit), .nh_reg_in(nh_reg_in), .oq_reg_in(oq_reg_in),
    .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack),
    .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_wr_ack(tbl_wr_ack),
    .stats_clear(stats_clear), .lookup_count(lookup_count), .hit_count(hit_count)
  );

  logic [127:0] m_tbl [32];
  int unsigned  m_lk, m_hit;
  int n_chk = 0, n_pass = 0;

  // edge-indexed event log, updated just after each rising edge
  int cyc = 0, done_cnt = 0, wrack_cnt = 0, rdack_cnt = 0;
  int done_cyc = 0, wrack_cyc = 0, rdack_cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (lookup_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc + 1; end
    if (tbl_wr_ack)  begin wrack_cnt <= wrack_cnt + 1; wrack_cyc <= cyc + 1; end
    if (tbl_rd_ack)  begin rdack_cnt <= rdack_cnt + 1; rdack_cyc <= cyc + 1; end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ip4(input int a, input int b, input int c, input int d);
    return {a[7:0], b[7:0], c[7:0], d[7:0]};
  endfunction

  function automatic logic [31:0] pfx(input int len);
    return (len == 0) ? 32'h0 : (32'hFFFF_FFFF << (32 - len));
  endfunction

  // longest prefix wins; among equal prefixes the first (lowest index) is kept
  task automatic ref_lookup(input logic [31:0] ip, output logic hit, output logic [31:0] nh, output logic [31:0] oq);
    int best_len = -1;
    hit = 1'b0; nh = 32'h0; oq = 32'h0;
    for (int i = 0; i < 32; i++) begin
      logic [127:0] e = m_tbl[i];
      int len = $countones(e[95:64]);
      if (e[31:0] != 32'hFFFF_FFFF && (ip & e[95:64]) == (e[127:96] & e[95:64]) && len > best_len) begin
        best_len = len; hit = 1'b1; nh = e[63:32]; oq = e[31:0];
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] ip);
    logic h; logic [31:0] nh, oq;
    ref_lookup(ip, h, nh, oq);
    chk({tag, "_hit"}, lpm_hit, h);
    chk({tag, "_nh"}, nh_reg_in, nh);
    chk({tag, "_oq"}, oq_reg_in, oq);
    m_lk++;
    if (h) m_hit++;
    chk({tag, "_lkcnt"}, lookup_count, m_lk);
    chk({tag, "_hitcnt"}, hit_count, m_hit);
  endtask

  task automatic wait_done(input string tag, input int prev);
    int s = cyc;
    while (done_cnt == prev && cyc - s < 200) @(negedge clk);
    chk({tag, "_done_seen"}, done_cnt != prev, 1);
  endtask
  task automatic wait_wrack(input string tag, input int prev);
    int s = cyc;
    while (wrack_cnt == prev && cyc - s < 200) @(negedge clk);
    chk({tag, "_wrack_seen"}, wrack_cnt != prev, 1);
  endtask
  task automatic wait_rdack(input string tag, input int prev);
    int s = cyc;
    while (rdack_cnt == prev && cyc - s < 200) @(negedge clk);
    chk({tag, "_rdack_seen"}, rdack_cnt != prev, 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; lookup_req = 1'b0; tbl_rd_req = 1'b0; tbl_wr_req = 1'b0; stats_clear = 32'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) m_tbl[i] = '1;
    m_lk = 0; m_hit = 0;
  endtask

  task automatic host_wr(input string tag, input logic [4:0] a, input logic [127:0] d);
    int c0 = cyc, prev = wrack_cnt;
    tbl_wr_req = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
    @(negedge clk); tbl_wr_req = 1'b0;
    wait_wrack(tag, prev);
    chk({tag, "_wrlat"}, wrack_cyc - c0, 3);
    m_tbl[a] = d;
  endtask

  task automatic host_rd(input string tag, input logic [4:0] a);
    int c0 = cyc, prev = rdack_cnt;
    tbl_rd_req = 1'b1; tbl_rd_addr = a;
    @(negedge clk); tbl_rd_req = 1'b0;
    wait_rdack(tag, prev);
    chk({tag, "_rdlat"}, rdack_cyc - c0, 3);
    chk({tag, "_rddata"}, tbl_rd_data, m_tbl[a]);
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] ip);
    int c0 = cyc, prev = done_cnt;
    lookup_req = 1'b1; lookup_ip = ip;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_busy"}, lookup_busy, 1);
    wait_done(tag, prev);
    lookup_req = 1'b0;
    chk({tag, "_lat"}, done_cyc - c0, 34);
    check_result(tag, ip);
  endtask

  initial begin
    logic [127:0] e;
    int c0, pd, pw, pr;
    tbl_rd_addr = '0; tbl_wr_addr = '0; tbl_wr_data = '0; lookup_ip = '0;
    do_reset();
    chk("rst_busy", lookup_busy, 0);
    chk("rst_hit", lpm_hit, 0);
    chk("rst_nh", nh_reg_in, 0);
    chk("rst_rddata", tbl_rd_data, 0);
    chk("rst_cnt", {lookup_count, hit_count}, 0);

    // basic write/read
    host_wr("w3", 5'd3, {ip4(10,0,0,0), ip4(255,0,0,0), ip4(10,0,0,1), 32'd2});
    host_rd("r3", 5'd3);
    host_rd("r4", 5'd4);
    chk("r4_ones", tbl_rd_data, {128{1'b1}});

    // lookups: /16 beats /8, fallback to /8, miss
    host_wr("w7", 5'd7, {ip4(10,1,0,0), ip4(255,255,0,0), ip4(10,1,0,9), 32'd4});
    do_lookup("lk1", ip4(10,1,2,3));
    chk("lk1_oq4", oq_reg_in, 4);
    do_lookup("lk2", ip4(10,2,0,1));
    do_lookup("lk3", ip4(192,168,1,1));
    chk("lk3_cnts", {lookup_count, hit_count}, {32'd3, 32'd2});
    stats_clear = 32'd1; @(negedge clk); stats_clear = 32'd0;
    m_lk = 0; m_hit = 0;
    chk("clr_cnts", {lookup_count, hit_count}, 0);

    // host write arriving mid-scan waits and does not alter the result
    c0 = cyc; pd = done_cnt; pw = wrack_cnt;
    lookup_req = 1'b1; lookup_ip = ip4(10,1,2,3);
    repeat (5) @(negedge clk);
    tbl_wr_req = 1'b1; tbl_wr_addr = 5'd10;
    tbl_wr_data = {ip4(10,1,2,0), ip4(255,255,255,0), ip4(10,1,2,99), 32'd6};
    @(negedge clk); tbl_wr_req = 1'b0;
    wait_done("mid", pd);
    lookup_req = 1'b0;
    chk("mid_lat", done_cyc - c0, 34);
    chk("mid_nowr", wrack_cnt, pw);
    check_result("mid", ip4(10,1,2,3));
    wait_wrack("mid", pw);
    chk("mid_wrafter", wrack_cyc - done_cyc, 2);
    m_tbl[10] = tbl_wr_data;
    do_lookup("mid2", ip4(10,1,2,3));

    // ties from reset: host first, then lookup, then host again
    do_reset();
    host_wr("wdef", 5'd20, {ip4(0,0,0,0), 32'h0, ip4(1,1,1,1), 32'd9});
    do_reset();
    c0 = cyc; pd = done_cnt; pw = wrack_cnt; pr = rdack_cnt;
    tbl_wr_req = 1'b1; tbl_wr_addr = 5'd20;
    tbl_wr_data = {ip4(0,0,0,0), 32'h0, ip4(1,1,1,1), 32'd9};
    @(negedge clk);
    tbl_wr_req = 1'b0; lookup_req = 1'b1; lookup_ip = ip4(8,8,8,8);
    wait_wrack("tie1", pw);
    chk("tie1_wrlat", wrack_cyc - c0, 3);
    m_tbl[20] = tbl_wr_data;
    repeat (4) @(negedge clk);
    tbl_rd_req = 1'b1; tbl_rd_addr = 5'd20;
    @(negedge clk); tbl_rd_req = 1'b0;
    wait_done("tie2", pd);
    chk("tie2_lat", done_cyc - c0, 37);
    check_result("tie2", ip4(8,8,8,8));
    pd = done_cnt;
    lookup_ip = ip4(9,9,9,9);
    wait_rdack("tie3", pr);
    chk("tie3_rdlat", rdack_cyc - done_cyc, 2);
    chk("tie3_rddata", tbl_rd_data, m_tbl[20]);
    wait_done("tie4", pd);
    lookup_req = 1'b0;
    chk("tie4_lat", done_cyc - rdack_cyc, 34);
    check_result("tie4", ip4(9,9,9,9));

    // equal-length prefixes: lower index wins
    host_wr("w5", 5'd5, {ip4(10,5,0,0), ip4(255,255,0,0), ip4(10,5,0,1), 32'd11});
    host_wr("w9", 5'd9, {ip4(10,5,0,0), ip4(255,255,0,0), ip4(10,5,0,2), 32'd22});
    do_lookup("eq", ip4(10,5,1,1));
    chk("eq_oq11", oq_reg_in, 11);

    // randomized mix of writes, reads and lookups
    for (int it = 0; it < 30; it++) begin
      int op = $urandom_range(0, 2);
      logic [31:0] rip = ip4(10, $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,255));
      if (op == 0) begin
        int len = $urandom_range(0, 32);
        e = {rip & pfx(len), pfx(len), $urandom, 32'($urandom_range(0, 15))};
        if ($urandom_range(0, 5) == 0) e[31:0] = 32'hFFFF_FFFF;
        host_wr("rw", 5'($urandom_range(0, 31)), e);
      end else if (op == 1) begin
        host_rd("rr", 5'($urandom_range(0, 31)));
      end else begin
        do_lookup("rl", rip);
      end
    end

    // reset in the middle of a scan
    pd = done_cnt;
    lookup_req = 1'b1; lookup_ip = ip4(10,1,2,3);
    repeat (13) @(negedge clk);
    rstn = 1'b0; lookup_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rs_busy_in", lookup_busy, 0);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) m_tbl[i] = '1;
    m_lk = 0; m_hit = 0;
    repeat (40) @(negedge clk);
    chk("rs_nodone", done_cnt, pd);
    chk("rs_busy", lookup_busy, 0);
    chk("rs_cnts", {lookup_count, hit_count}, 0);
    host_rd("rs_r3", 5'd3);
    host_rd("rs_r7", 5'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lpm_table_ctrl.md
Name: lpm_table_ctrl

Overview:
Owns the 32-entry LPM route table and sequences every access to it. Shares the single table port between two requesters: the datapath lookup (header stage: lpm_hit / next-hop / output-queue) and host register-path table reads and writes. Serialises the two sides so a host write never lands mid-scan. Performs longest-prefix match as a one-entry-per-cycle scan and returns registered results plus statistics counters.

Parameters:
C_S_AXI_DATA_WIDTH, 32, register/counter width
TBL_DEPTH, 32, number of route entries
TBL_ADDR_WIDTH, 5, log2(TBL_DEPTH)

Ports:
AXI_ACLK  in  1  clock
AXI_RESETN  in  1  synchronous active-low reset
lookup_req  in  1  level; held with lookup_ip stable until lookup_done
lookup_ip  in  32  destination IPv4 address
lookup_busy  out  1  high from acceptance until lookup_done
lookup_done  out  1  one-cycle pulse; results valid this cycle and held until next done
lpm_hit  out  1  match found
nh_reg_in  out  32  next hop of winning entry (0 on miss)
oq_reg_in  out  32  output queue of winning entry (0 on miss)
tbl_rd_req  in  1  one-cycle request pulse
tbl_rd_addr  in  5  entry to read
tbl_rd_data  out  128  entry contents, valid with tbl_rd_ack
tbl_rd_ack  out  1  one-cycle pulse
tbl_wr_req  in  1  one-cycle request pulse
tbl_wr_addr  in  5  entry to write
tbl_wr_data  in  128  entry contents
tbl_wr_ack  out  1  one-cycle pulse
stats_clear  in  32  value 32'd1 clears counters
lookup_count  out  32  lookups completed
hit_count  out  32  lookups with lpm_hit=1

Behaviour:
- Clock and reset: single clock AXI_ACLK; reset is synchronous, active-low, on AXI_RESETN.
- Entry layout: [127:96] ip, [95:64] mask, [63:32] next_hop, [31:0] oq.
- An entry is empty when its oq field is 32'hFFFFFFFF.
- Reset (AXI_RESETN=0 at any clock edge, including mid-scan or with requests pending):
  - every entry becomes 128'hFFFF...F;
  - FSM goes to IDLE; pending flags clear;
  - all outputs go to 0, including counters and tbl_rd_data.
- Host request capture:
  - A tbl_wr_req pulse latches addr/data into wr_pending; a tbl_rd_req pulse latches addr into rd_pending.
  - A pulse arriving while the same pending flag is already set is dropped.
  - Capture happens in any state.
- FSM states: IDLE, SCAN, HOST_WR, HOST_RD, DONE.
- IDLE arbitration:
  - Candidates are host (wr_pending or rd_pending) and lookup (lookup_req).
  - If only one side requests, it is granted.
  - If both request, round-robin on a last_grant bit: the side not granted last wins. The bit resets to "lookup", so host wins the first tie.
  - Within host, write has priority over read.
  - Granting lookup latches lookup_ip and goes to SCAN with index=0.
- HOST_WR (1 cycle): table[addr] <= data; tbl_wr_ack=1; clear wr_pending; next state IDLE.
- HOST_RD (1 cycle): tbl_rd_data <= table[addr]; tbl_rd_ack=1; clear rd_pending; next state IDLE.
- SCAN (TBL_DEPTH cycles, index 0..31):
  - Entry matches when it is non-empty and (lookup_ip & mask) == (ip & mask).
  - A match replaces the current best when no best exists yet, or when its mask > best mask (unsigned compare).
  - Equal masks keep the lower index. A mask of 0 is a valid default route.
  - After index 31, go to DONE.
- DONE (1 cycle):
  - lookup_done=1; lpm_hit, nh_reg_in and oq_reg_in are registered from the best entry (0 on miss).
  - lookup_count increments; hit_count increments on a hit.
  - Next state IDLE; lookup_busy drops.
- Latency:
  - Lookup granted at cycle t gives lookup_done at t+33, when uncontended.
  - Host request captured at t: ack at t+2 if IDLE; otherwise at most one full lookup (34 cycles) later.
- Counters: wrap at 2^32-1 → 0. stats_clear==1 zeroes both counters every cycle it is held; clear wins over a simultaneous increment.
- Host requests received during SCAN stay pending. The table is never modified during a scan.

Test Plan:
1. Reset, then write entry 3 = {10.0.0.0, 255.0.0.0, 10.0.0.1, 2}; read entry 3 → tbl_wr_ack, then tbl_rd_ack with matching 128-bit data; read entry 4 → all-ones.
2. Add entry 7 = {10.1.0.0, 255.255.0.0, 10.1.0.9, 4}; lookup 10.1.2.3 → lookup_done at t+33, lpm_hit=1, nh=10.1.0.9, oq=4. Lookup 10.2.0.1 → nh=10.0.0.1, oq=2.
3. Lookup 192.168.1.1 with no default route → lpm_hit=0, nh=0, oq=0; lookup_count=3, hit_count=2. Then stats_clear=1 for one cycle → both counters 0.
4. Lookup at t and tbl_wr_req at t+5 → write ack no earlier than cycle after lookup_done; the scan result is unaffected by the new entry. Same-cycle lookup+write from IDLE → host first, then lookup, then host on the next tie.
5. Two equal /16 entries at indices 5 and 9 with different oq → index 5 result returned.
6. Assert AXI_RESETN=0 at scan index 12 → lookup_busy=0, no lookup_done, table reads all-ones afterwards, counters 0.
